counter_bank: RTL

// - Parametrised successor of the fixed three-channel 8-bit counter design under the simulation top.
// - NUM_CH independent counters of WIDTH bits. Each channel has its own enable, step, mode and load.
// - Per-channel wrap/clamp event pulses for Lua-side checks.
// - Atomic all-channel snapshot port with a valid/ready handshake, sampled by the testbench.

---
 rtl/counter_bank_pkg.sv | 16 +
 rtl/counter_lane.sv | 89 ++++++++
 rtl/counter_bank.sv | 75 +++++++
 3 files changed

// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: per-channel counting mode encoding.
// Contents:
//   MODE_W  width of one channel's mode field
//   mode_e  counting mode (wrap/saturate, up/down)
package counter_bank_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    UP_WRAP = 2'd0,
    DN_WRAP = 2'd1,
    UP_SAT  = 2'd2,
    DN_SAT  = 2'd3
  } mode_e;

endpackage

// File: rtl/counter_lane.sv
// One counter channel: count register, next-value arithmetic and wrap/clamp event.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   en          count enable
//   mode        counting mode for this update
//   step        increment/decrement amount (zero-extended)
//   load        synchronous load strobe (wins over en)
//   load_val    value taken on load
//   count       registered counter value
//   evt         registered 1-cycle pulse on wrap or clamp
module counter_lane
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  mode_e             mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              evt
);

  // Arithmetic is wide enough for the larger operand plus a carry bit.
  localparam int unsigned SW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;
  localparam logic [SW-1:0] MAXV = SW'((64'd1 << WIDTH) - 64'd1);

  logic [SW-1:0]    ext_count;
  logic [SW-1:0]    ext_step;
  logic [SW-1:0]    sum;
  logic             borrow;
  logic             over;
  logic [WIDTH-1:0] count_nxt;
  logic             evt_nxt;

  // Next-value and event selection.
  always_comb begin
    ext_count = SW'(count);
    ext_step  = SW'(step);
    sum       = ext_count + ext_step;
    over      = (sum > MAXV);
    borrow    = (ext_step > ext_count);
    count_nxt = count;
    evt_nxt   = 1'b0;
    if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      case (mode)
        UP_WRAP: begin
          count_nxt = WIDTH'(sum);
          evt_nxt   = over;
        end
        DN_WRAP: begin
          count_nxt = WIDTH'(ext_count - ext_step);
          evt_nxt   = borrow;
        end
        UP_SAT: begin
          count_nxt = over ? WIDTH'(MAXV) : WIDTH'(sum);
          evt_nxt   = over;
        end
        DN_SAT: begin
          count_nxt = borrow ? '0 : WIDTH'(ext_count - ext_step);
          evt_nxt   = borrow;
        end
        default: begin
          count_nxt = count;
          evt_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Counter and event registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= WIDTH'(INIT_VAL);
      evt   <= 1'b0;
    end else begin
      count <= count_nxt;
      evt   <= evt_nxt;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent counters with an atomic all-channel snapshot port.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   en/mode/step/load/load_val  per-channel controls, channel i in slice i
//   count, evt   registered per-channel values and wrap/clamp pulses
//   snap_req     request a snapshot of all counts
//   snap_valid/snap_ready/snap_data  snapshot handshake and captured counts
//   snap_drop    1-cycle pulse when a request hit a busy slot
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        en,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [STEP_W*NUM_CH-1:0] step,
  input  logic [NUM_CH-1:0]        load,
  input  logic [WIDTH*NUM_CH-1:0]  load_val,
  output logic [WIDTH*NUM_CH-1:0]  count,
  output logic [NUM_CH-1:0]        evt,
  input  logic                     snap_req,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [WIDTH*NUM_CH-1:0]  snap_data,
  output logic                     snap_drop
);

  logic slot_free;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    counter_lane #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .INIT_VAL (INIT_VAL)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .mode     (mode_e'(mode[MODE_W*i +: MODE_W])),
      .step     (step[STEP_W*i +: STEP_W]),
      .load     (load[i]),
      .load_val (load_val[WIDTH*i +: WIDTH]),
      .count    (count[WIDTH*i +: WIDTH]),
      .evt      (evt[i])
    );
  end

  // Slot frees up in the same cycle the consumer takes the current snapshot.
  assign slot_free = !snap_valid || snap_ready;

  // Snapshot capture and handshake; captures pre-update counts of all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
      snap_drop  <= 1'b0;
    end else begin
      snap_drop <= 1'b0;
      if (snap_req && slot_free) begin
        snap_data  <= count;
        snap_valid <= 1'b1;
      end else if (snap_req) begin
        snap_drop <= 1'b1;
      end else if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
    end
  end

endmodule
